// File: rtl/comm_fpga_pkg.sv
// Shared types and constants for the EPP comm bridge.
package comm_fpga_pkg;

  localparam int EPP_DATA_W = 8;
  localparam logic [EPP_DATA_W-1:0] TIMEOUT_READ_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR_WAIT = 3'd1,
    S_WR_EXEC   = 3'd2,
    S_RD_EXEC   = 3'd3,
    S_WR_WAIT   = 3'd4,
    S_RD_WAIT   = 3'd5
  } state_t;

endpackage

// File: rtl/comm_fpga_sync.sv
// STAGES-deep flop chain for bringing an asynchronous EPP pin into the eppClk domain.
module comm_fpga_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift chain; reset loads the inactive level
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/comm_fpga_epp_ctrl.sv
// EPP-to-channel bridge: host EPP cycles become h2f/f2h channel transfers.
// Optional EXEC-state stall timeout enabled by defining COMM_FPGA_EPP_TIMEOUT_EN.
module comm_fpga_epp_ctrl
  import comm_fpga_pkg::*;
#(
  parameter int CHAN_BITS      = 7,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  eppClk_in,
  input  logic                  reset_in,
  inout  wire  [EPP_DATA_W-1:0] eppData_io,
  input  logic                  eppAddrStb_in,
  input  logic                  eppDataStb_in,
  input  logic                  eppWrite_in,
  output logic                  eppWait_out,
  output logic [CHAN_BITS-1:0]  chanAddr_out,
  output logic [EPP_DATA_W-1:0] h2fData_out,
  output logic                  h2fValid_out,
  input  logic                  h2fReady_in,
  input  logic [EPP_DATA_W-1:0] f2hData_in,
  input  logic                  f2hValid_in,
  output logic                  f2hReady_out,
  output logic                  timeout_out
);

  state_t                 state, stateNext;
  logic                   addrStbSync, dataStbSync, writeSync;
  logic [EPP_DATA_W-1:0]  readReg, readNext, h2fDataNext;
  logic [CHAN_BITS-1:0]   chanNext;
  logic                   waitNext, h2fValidNext, f2hReadyNext;

  comm_fpga_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uAddrSync (
    .clk(eppClk_in), .reset(reset_in), .d(eppAddrStb_in), .q(addrStbSync)
  );
  comm_fpga_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uDataSync (
    .clk(eppClk_in), .reset(reset_in), .d(eppDataStb_in), .q(dataStbSync)
  );
  comm_fpga_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uWriteSync (
    .clk(eppClk_in), .reset(reset_in), .d(eppWrite_in), .q(writeSync)
  );

  // Direction follows the raw pin so the bus turns round as soon as the host asks
  assign eppData_io = eppWrite_in ? readReg : {EPP_DATA_W{1'bz}};

`ifdef COMM_FPGA_EPP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] toCnt, toCntNext;
  logic            toPulse, toPulseNext;
  assign timeout_out = toPulse;
`else
  assign timeout_out = 1'b0;
`endif

  // Next-state, next-output and datapath-load decode
  always_comb begin
    stateNext   = state;
    waitNext    = eppWait_out;
    chanNext    = chanAddr_out;
    readNext    = readReg;
    h2fDataNext = h2fData_out;
`ifdef COMM_FPGA_EPP_TIMEOUT_EN
    toCntNext   = '0;
    toPulseNext = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        waitNext = 1'b0;
        if (addrStbSync == 1'b0) begin
          waitNext  = 1'b1;
          stateNext = S_ADDR_WAIT;
          if (writeSync == 1'b0) begin
            chanNext = eppData_io[CHAN_BITS-1:0];
          end else begin
            readNext = EPP_DATA_W'(chanAddr_out);
          end
        end else if (dataStbSync == 1'b0) begin
          if (writeSync == 1'b0) begin
            h2fDataNext = eppData_io;
            stateNext   = S_WR_EXEC;
          end else begin
            stateNext = S_RD_EXEC;
          end
        end else begin
          stateNext = S_IDLE;
        end
      end
      S_ADDR_WAIT: begin
        if (addrStbSync == 1'b1) begin
          waitNext  = 1'b0;
          stateNext = S_IDLE;
        end else begin
          stateNext = S_ADDR_WAIT;
        end
      end
      S_WR_EXEC: begin
        if (h2fReady_in == 1'b1) begin
          waitNext  = 1'b1;
          stateNext = S_WR_WAIT;
        end else begin
`ifdef COMM_FPGA_EPP_TIMEOUT_EN
          if (toCnt == TO_LAST) begin
            waitNext    = 1'b1;
            toPulseNext = 1'b1;
            stateNext   = S_WR_WAIT;
          end else begin
            toCntNext = toCnt + TO_W'(1);
          end
`else
          stateNext = S_WR_EXEC;
`endif
        end
      end
      S_RD_EXEC: begin
        if (f2hValid_in == 1'b1) begin
          readNext  = f2hData_in;
          waitNext  = 1'b1;
          stateNext = S_RD_WAIT;
        end else begin
`ifdef COMM_FPGA_EPP_TIMEOUT_EN
          if (toCnt == TO_LAST) begin
            readNext    = TIMEOUT_READ_BYTE;
            waitNext    = 1'b1;
            toPulseNext = 1'b1;
            stateNext   = S_RD_WAIT;
          end else begin
            toCntNext = toCnt + TO_W'(1);
          end
`else
          stateNext = S_RD_EXEC;
`endif
        end
      end
      S_WR_WAIT, S_RD_WAIT: begin
        if (dataStbSync == 1'b1) begin
          waitNext  = 1'b0;
          stateNext = S_IDLE;
        end else begin
          stateNext = state;
        end
      end
      default: begin
        waitNext  = 1'b0;
        stateNext = S_IDLE;
      end
    endcase
    // Handshake strobes are registered copies of the state they belong to
    h2fValidNext = (stateNext == S_WR_EXEC);
    f2hReadyNext = (stateNext == S_RD_EXEC);
  end

  // State and registered outputs
  always_ff @(posedge eppClk_in) begin
    if (reset_in) begin
      state        <= S_IDLE;
      eppWait_out  <= 1'b0;
      chanAddr_out <= '0;
      readReg      <= 8'h00;
      h2fData_out  <= 8'h00;
      h2fValid_out <= 1'b0;
      f2hReady_out <= 1'b0;
`ifdef COMM_FPGA_EPP_TIMEOUT_EN
      toCnt        <= '0;
      toPulse      <= 1'b0;
`endif
    end else begin
      state        <= stateNext;
      eppWait_out  <= waitNext;
      chanAddr_out <= chanNext;
      readReg      <= readNext;
      h2fData_out  <= h2fDataNext;
      h2fValid_out <= h2fValidNext;
      f2hReady_out <= f2hReadyNext;
`ifdef COMM_FPGA_EPP_TIMEOUT_EN
      toCnt        <= toCntNext;
      toPulse      <= toPulseNext;
`endif
    end
  end

endmodule
